// File: rtl/seg_decode_if.sv
// Bus between a scanned seven-segment display and its loopback decoder.
// The master drives the scanned lines; the slave returns the decoded per-digit state.
interface seg_decode_if #(parameter int NDIG = 8);
   logic [7:0]        seg_in;
   logic [NDIG-1:0]   an_in;
   logic [4*NDIG-1:0] digits;
   logic [NDIG-1:0]   dig_valid;
   logic [NDIG-1:0]   dig_blank;
   logic [NDIG-1:0]   dig_dp;
   logic              upd;
   logic [2:0]        upd_idx;
   logic [3:0]        upd_val;
   logic              err;
   logic [7:0]        err_cnt;

   modport master (
      output seg_in, an_in,
      input  digits, dig_valid, dig_blank, dig_dp, upd, upd_idx, upd_val, err, err_cnt
   );

   modport slave (
      input  seg_in, an_in,
      output digits, dig_valid, dig_blank, dig_dp, upd, upd_idx, upd_val, err, err_cnt
   );
endinterface

// File: rtl/seg_decode.sv
// Scanned seven-segment decoder: recovers the hex value on each digit of a
// time-multiplexed active-low display once a pattern has been stable long enough.
module seg_digit (
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_hex,
   input  logic       wr_blank,
   input  logic       wr_ill,
   input  logic [3:0] val,
   input  logic       dp,
   output logic [3:0] digit,
   output logic       valid,
   output logic       blank,
   output logic       dp_q
);
   always_ff @(posedge clk) begin
      if (rst) begin
         digit <= 4'h0;
         valid <= 1'b0;
         blank <= 1'b0;
         dp_q  <= 1'b0;
      end else if (wr_hex) begin
         digit <= val;
         valid <= 1'b1;
         blank <= 1'b0;
         dp_q  <= dp;
      end else if (wr_blank) begin
         valid <= 1'b0;
         blank <= 1'b1;
         dp_q  <= dp;
      end else if (wr_ill) begin
         valid <= 1'b0;
      end
   end
endmodule

module seg_decode #(
   parameter int NDIG       = 8,
   parameter int STABLE_CYC = 4
) (
   input logic         clk,
   input logic         rst,
   seg_decode_if.slave bus
);
   typedef enum logic [1:0] {IDLE, TRACK, MULTI, HOLD} state_t;

   state_t            state, state_nxt;
   logic [7:0]        s_seg;
   logic [NDIG-1:0]   s_an;
   logic [3:0]        cnt;
   logic              chg, hit;
   logic [3:0]        nlow_in;
   logic [2:0]        idx;
   logic [7:0]        pat;
   logic [3:0]        hex;
   logic              legal, is_blank;
   logic              do_commit, do_err;
   logic              wr_hex, wr_blank, wr_ill, err_go;

   logic [NDIG-1:0][3:0] dig_q;
   logic [NDIG-1:0]      vld_q, blk_q, dp_q;

   // Change is seen on the edge that first samples it, so the count starts right away.
   assign chg = ({bus.seg_in, bus.an_in} != {s_seg, s_an});
   assign hit = !chg && (cnt == 4'(STABLE_CYC - 1));
   assign pat = {s_seg[7:1], 1'b1};

   always_comb begin
      nlow_in = 4'd0;
      for (int i = 0; i < NDIG; i++)
         if (!bus.an_in[i]) nlow_in = nlow_in + 4'd1;
   end

   always_comb begin
      idx = 3'd0;
      for (int i = 0; i < NDIG; i++)
         if (!s_an[i]) idx = 3'(i);
   end

   always_comb begin
      hex      = 4'h0;
      legal    = 1'b1;
      is_blank = 1'b0;
      case (pat)
         8'h03: hex = 4'h0;
         8'hF3: hex = 4'h1;
         8'h25: hex = 4'h2;
         8'h0D: hex = 4'h3;
         8'h99: hex = 4'h4;
         8'h49: hex = 4'h5;
         8'h41: hex = 4'h6;
         8'h1F: hex = 4'h7;
         8'h01: hex = 4'h8;
         8'h19: hex = 4'h9;
         8'h11: hex = 4'hA;
         8'hC1: hex = 4'hB;
         8'h63: hex = 4'hC;
         8'h85: hex = 4'hD;
         8'h61: hex = 4'hE;
         8'h71: hex = 4'hF;
         8'hFF: begin legal = 1'b0; is_blank = 1'b1; end
         default: legal = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         s_seg <= 8'hFF;
         s_an  <= '1;
         cnt   <= 4'd0;
      end else begin
         state <= state_nxt;
         s_seg <= bus.seg_in;
         s_an  <= bus.an_in;
         if (chg)
            cnt <= 4'd0;
         else if (cnt < 4'(STABLE_CYC))
            cnt <= cnt + 4'd1;
      end
   end

   always_comb begin
      state_nxt = state;
      do_commit = 1'b0;
      do_err    = 1'b0;
      if (chg) begin
         if (nlow_in == 4'd1)      state_nxt = TRACK;
         else if (nlow_in >= 4'd2) state_nxt = MULTI;
         else                      state_nxt = IDLE;
      end else begin
         case (state)
            TRACK: if (hit) begin state_nxt = HOLD; do_commit = 1'b1; end
            MULTI: if (hit) begin state_nxt = HOLD; do_err    = 1'b1; end
            default: ;
         endcase
      end
   end

   assign wr_hex   = do_commit && legal;
   assign wr_blank = do_commit && is_blank;
   assign wr_ill   = do_commit && !legal && !is_blank;
   assign err_go   = do_err || wr_ill;

   for (genvar i = 0; i < NDIG; i++) begin : g_dig
      seg_digit u_dig (
         .clk      (clk),
         .rst      (rst),
         .wr_hex   (wr_hex   && !s_an[i]),
         .wr_blank (wr_blank && !s_an[i]),
         .wr_ill   (wr_ill   && !s_an[i]),
         .val      (hex),
         .dp       (~s_seg[0]),
         .digit    (dig_q[i]),
         .valid    (vld_q[i]),
         .blank    (blk_q[i]),
         .dp_q     (dp_q[i])
      );
   end

   assign bus.digits    = dig_q;
   assign bus.dig_valid = vld_q;
   assign bus.dig_blank = blk_q;
   assign bus.dig_dp    = dp_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.upd     <= 1'b0;
         bus.upd_idx <= 3'd0;
         bus.upd_val <= 4'h0;
         bus.err     <= 1'b0;
         bus.err_cnt <= 8'd0;
      end else begin
         bus.upd <= wr_hex;
         bus.err <= err_go;
         if (wr_hex) begin
            bus.upd_idx <= idx;
            bus.upd_val <= hex;
         end
         if (err_go && bus.err_cnt != 8'hFF)
            bus.err_cnt <= bus.err_cnt + 8'd1;
      end
   end
endmodule

// File: tb/tb_seg_decode.sv
// Directed bench for seg_decode; a scoreboard queue holds every expected upd/err event.
module tb_seg_decode;
   typedef struct packed {
      logic       is_err;
      logic [2:0] idx;
      logic [3:0] val;
   } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   n_upd  = 0;
   ev_t  exp_q[$];

   seg_decode_if #(.NDIG(8)) bus ();

   seg_decode #(.NDIG(8), .STABLE_CYC(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic step(input logic [7:0] seg, input logic [7:0] an);
      @(negedge clk);
      bus.seg_in = seg;
      bus.an_in  = an;
   endtask

   task automatic push_upd(input logic [2:0] idx, input logic [3:0] val);
      ev_t e;
      e.is_err = 1'b0;
      e.idx    = idx;
      e.val    = val;
      exp_q.push_back(e);
   endtask

   task automatic push_err();
      ev_t e;
      e.is_err = 1'b1;
      e.idx    = 3'd0;
      e.val    = 4'h0;
      exp_q.push_back(e);
   endtask

   // Scoreboard side: every upd/err pulse must match the oldest expected event.
   always @(negedge clk) begin
      if (!rst && (bus.upd || bus.err)) begin
         ev_t e;
         if (bus.upd) n_upd++;
         chk("upd_err_excl", {31'd0, bus.upd & bus.err}, 32'd0);
         if (exp_q.size() == 0) begin
            chk("unexpected_event", {31'd0, bus.err}, {31'd0, ~bus.err});
         end else begin
            e = exp_q.pop_front();
            chk("ev_kind", {31'd0, bus.err}, {31'd0, e.is_err});
            if (!e.is_err) begin
               chk("ev_idx", {29'd0, bus.upd_idx}, {29'd0, e.idx});
               chk("ev_val", {28'd0, bus.upd_val}, {28'd0, e.val});
            end
         end
      end
   end

   task automatic chk_all_zero(input string tag);
      chk({tag, "_digits"},  bus.digits, 32'd0);
      chk({tag, "_valid"},   {24'd0, bus.dig_valid}, 32'd0);
      chk({tag, "_blank"},   {24'd0, bus.dig_blank}, 32'd0);
      chk({tag, "_dp"},      {24'd0, bus.dig_dp}, 32'd0);
      chk({tag, "_upd"},     {31'd0, bus.upd}, 32'd0);
      chk({tag, "_upd_idx"}, {29'd0, bus.upd_idx}, 32'd0);
      chk({tag, "_upd_val"}, {28'd0, bus.upd_val}, 32'd0);
      chk({tag, "_err"},     {31'd0, bus.err}, 32'd0);
      chk({tag, "_err_cnt"}, {24'd0, bus.err_cnt}, 32'd0);
   endtask

   initial begin
      logic [7:0] pats [8];
      int upd_base;
      pats = '{8'h03, 8'hF3, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F};
      bus.seg_in = 8'hFF;
      bus.an_in  = 8'hFF;

      // Reset state
      repeat (3) @(posedge clk);
      #1 chk_all_zero("reset");

      // Single digit: latency of 5 edges from first sample
      @(negedge clk);
      rst = 1'b0;
      bus.seg_in = 8'h25;
      bus.an_in  = 8'hFE;
      push_upd(3'd0, 4'h2);
      repeat (4) @(posedge clk);
      #1 chk("t1_upd_early", {31'd0, bus.upd}, 32'd0);
      @(posedge clk);
      #1 chk("t1_upd", {31'd0, bus.upd}, 32'd1);
      chk("t1_upd_idx", {29'd0, bus.upd_idx}, 32'd0);
      chk("t1_upd_val", {28'd0, bus.upd_val}, 32'd2);
      chk("t1_digit0", {28'd0, bus.digits[3:0]}, 32'd2);
      chk("t1_valid", {24'd0, bus.dig_valid}, 32'h01);
      @(posedge clk);
      #1 chk("t1_upd_fall", {31'd0, bus.upd}, 32'd0);

      // Full scan of all digits
      upd_base = n_upd;
      for (int i = 0; i < 8; i++) begin
         logic [7:0] an;
         an = ~(8'd1 << i);
         step(pats[i], an);
         push_upd(3'(i), 4'(i));
         repeat (8) @(posedge clk);
      end
      #1 chk("scan_digits", bus.digits, 32'h76543210);
      chk("scan_valid", {24'd0, bus.dig_valid}, 32'hFF);
      chk("scan_upd_count", n_upd - upd_base, 32'd8);

      // Short-lived pattern is dropped; dp bit ignored for matching
      step(8'h85, 8'hF7);
      repeat (3) @(posedge clk);
      step(8'h60, 8'hF7);
      push_upd(3'd3, 4'hE);
      repeat (8) @(posedge clk);
      #1 chk("short_digit3", {28'd0, bus.digits[15:12]}, 32'hE);
      chk("short_dp3", {31'd0, bus.dig_dp[3]}, 32'd1);

      // Illegal pattern then blank on digit 2
      step(8'h55, 8'hFB);
      push_err();
      repeat (10) @(posedge clk);
      #1 chk("ill_err_cnt", {24'd0, bus.err_cnt}, 32'd1);
      chk("ill_valid2", {31'd0, bus.dig_valid[2]}, 32'd0);
      chk("ill_digit2", {28'd0, bus.digits[11:8]}, 32'd2);
      step(8'hFF, 8'hFB);
      repeat (8) @(posedge clk);
      #1 chk("blank2", {31'd0, bus.dig_blank[2]}, 32'd1);
      chk("blank_valid2", {31'd0, bus.dig_valid[2]}, 32'd0);
      chk("blank_digit2", {28'd0, bus.digits[11:8]}, 32'd2);

      // Two anodes low
      step(8'h03, 8'hFC);
      push_err();
      repeat (6) @(posedge clk);
      #1 chk("multi_err_cnt", {24'd0, bus.err_cnt}, 32'd2);
      chk("multi_digits", bus.digits, 32'h7654E210);

      // Reset mid-episode, value held across release
      step(8'h01, 8'hDF);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 chk_all_zero("mid_rst");
      @(negedge clk);
      rst = 1'b0;
      push_upd(3'd5, 4'h8);
      repeat (4) @(posedge clk);
      #1 chk("rst_upd_early", {31'd0, bus.upd}, 32'd0);
      @(posedge clk);
      #1 chk("rst_upd", {31'd0, bus.upd}, 32'd1);
      chk("rst_upd_val", {28'd0, bus.upd_val}, 32'd8);
      chk("rst_upd_idx", {29'd0, bus.upd_idx}, 32'd5);
      chk("rst_digits", bus.digits, 32'h00800000);

      repeat (5) @(posedge clk);
      #1 chk("queue_empty", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
